// File: rtl/aes_dec_word_io.sv
// Word-serial wrapper around a combinational AES-128 decryption core:
// gathers 4 key + 4 ciphertext words, waits for the core to settle, streams 4 plaintext words.
module aes_dec_word_io #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic [127:0] core_key,
    output logic [127:0] core_in,
    input  logic [127:0] core_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned WIDX_W  = 3;
    localparam int unsigned OIDX_W  = 2;
    localparam int unsigned CNT_W   = 4;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDX_W-1:0]  word_idx_q, word_idx_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic [OIDX_W-1:0]  out_idx_q, out_idx_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic [BLOCK_W-1:0] ct_q, ct_d;
    logic [BLOCK_W-1:0] result_q, result_d;

    logic              in_ready_d;
    logic              busy_d;
    logic              out_valid_d;
    logic              out_last_d;
    logic [WORD_W-1:0] out_data_d;

    logic in_fire;
    logic out_fire;
    logic settle_done;

    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready;
    assign settle_done = (settle_q == SETTLE_LAST);

    assign core_key = key_q;
    assign core_in  = ct_q;

    // Word slot 0 is the most significant 32 bits of a block.
    function automatic logic [BLOCK_W-1:0] put_word(
        input logic [BLOCK_W-1:0] blk,
        input logic [1:0]         slot,
        input logic [WORD_W-1:0]  w
    );
        logic [BLOCK_W-1:0] r;
        r = blk;
        case (slot)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] get_word(
        input logic [BLOCK_W-1:0] blk,
        input logic [1:0]         slot
    );
        logic [WORD_W-1:0] r;
        case (slot)
            2'd0:    r = blk[127:96];
            2'd1:    r = blk[95:64];
            2'd2:    r = blk[63:32];
            default: r = blk[31:0];
        endcase
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (in_fire && (word_idx_q == 3'd7)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (settle_done) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_fire && (out_idx_q == 2'd3)) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Datapath next values: word assembly, settle timing, result capture, output index
    always_comb begin
        word_idx_d = word_idx_q;
        settle_d   = settle_q;
        out_idx_d  = out_idx_q;
        key_d      = key_q;
        ct_d       = ct_q;
        result_d   = result_q;
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    word_idx_d = word_idx_q + 3'd1;
                    settle_d   = '0;
                    if (!word_idx_q[2]) begin
                        key_d = put_word(key_q, word_idx_q[1:0], in_data);
                    end else begin
                        ct_d = put_word(ct_q, word_idx_q[1:0], in_data);
                    end
                end
            end
            WAIT: begin
                settle_d = settle_q + 4'd1;
                if (settle_done) begin
                    result_d = core_out;
                end
            end
            SEND: begin
                if (out_fire) begin
                    out_idx_d = out_idx_q + 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx_q <= '0;
            settle_q   <= '0;
            out_idx_q  <= '0;
            key_q      <= '0;
            ct_q       <= '0;
            result_q   <= '0;
        end else begin
            word_idx_q <= word_idx_d;
            settle_q   <= settle_d;
            out_idx_q  <= out_idx_d;
            key_q      <= key_d;
            ct_q       <= ct_d;
            result_q   <= result_d;
        end
    end

    // Output decode from next state so every handshake output comes straight from a flop
    always_comb begin
        in_ready_d  = 1'b0;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = '0;
        case (state_d)
            LOAD: in_ready_d = 1'b1;
            WAIT: busy_d = 1'b1;
            SEND: begin
                busy_d      = 1'b1;
                out_valid_d = 1'b1;
                out_last_d  = (out_idx_d == 2'd3);
                out_data_d  = get_word(result_d, out_idx_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            in_ready  <= in_ready_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            out_data  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_aes_dec_word_io.sv
// Bench for aes_dec_word_io: queue-based reference model with a settling core stand-in,
// plus directed FIPS-197 vectors checked against literal plaintext.
module tb_aes_dec_word_io;

    localparam int unsigned S = 2;

    localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [127:0] core_key;
    logic [127:0] core_in;
    logic [127:0] core_out;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         busy;

    int errors = 0;
    int checks = 0;

    aes_dec_word_io #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .core_key  (core_key),
        .core_in   (core_in),
        .core_out  (core_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decryption: known vectors, otherwise an arbitrary but deterministic mix
    function automatic logic [127:0] ref_dec(input logic [127:0] k, input logic [127:0] c);
        if (k == KA && c == CA) return PA;
        if (k == KB && c == CB) return PB;
        return k ^ {c[63:0], c[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
    endfunction

    // Core stand-in: output is wrong until inputs have been stable for S-1 full edges
    logic [255:0] core_prev = 'x;
    int           stable    = 0;
    always @(negedge clk) begin
        if ({core_key, core_in} !== core_prev) begin
            core_prev = {core_key, core_in};
            stable = 0;
        end else if (stable < 1000) begin
            stable++;
        end
    end
    always_comb begin
        core_out = ref_dec(core_key, core_in);
        if (stable < int'(S) - 1) core_out = ~core_out;
    end

    // Reference model: words in, S-cycle latency, 4 words out in order
    logic [31:0]  mk[4];
    logic [31:0]  mc[4];
    int           m_words = 0;
    int           m_wait  = 0;
    logic [31:0]  mq[$];
    logic         mlq[$];
    logic [127:0] m_plain;
    logic         exp_ready;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin mk[i] = '0; mc[i] = '0; end
            m_words = 0;
            m_wait  = 0;
            mq.delete();
            mlq.delete();
            chk("rst_busy", 128'(busy), 128'(0));
            chk("rst_out_valid", 128'(out_valid), 128'(0));
            chk("rst_out_data", 128'(out_data), 128'(0));
            chk("rst_out_last", 128'(out_last), 128'(0));
            chk("rst_core_key", core_key, 128'(0));
            chk("rst_core_in", core_in, 128'(0));
        end else begin
            exp_ready = (mq.size() == 0) && (m_wait == 0);
            chk("in_ready", 128'(in_ready), 128'(exp_ready));
            chk("busy", 128'(busy), 128'(!exp_ready));
            chk("out_valid", 128'(out_valid), 128'(mq.size() != 0));
            chk("out_data", 128'(out_data), 128'((mq.size() != 0) ? mq[0] : 32'h0));
            chk("out_last", 128'(out_last), 128'((mq.size() != 0) ? mlq[0] : 1'b0));
            chk("core_key", core_key, {mk[0], mk[1], mk[2], mk[3]});
            chk("core_in", core_in, {mc[0], mc[1], mc[2], mc[3]});
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    for (int i = 0; i < 4; i++) begin
                        mq.push_back(32'(m_plain >> (96 - 32 * i)));
                        mlq.push_back(i == 3);
                    end
                end
            end else if (mq.size() != 0) begin
                if (out_ready) begin
                    void'(mq.pop_front());
                    void'(mlq.pop_front());
                end
            end else if (in_valid) begin
                if (m_words < 4) mk[m_words] = in_data;
                else             mc[m_words - 4] = in_data;
                m_words++;
                if (m_words == 8) begin
                    m_words = 0;
                    m_plain = ref_dec({mk[0], mk[1], mk[2], mk[3]}, {mc[0], mc[1], mc[2], mc[3]});
                    m_wait  = int'(S);
                end
            end
        end
    end

    // Collect every accepted output word
    logic [31:0] got_w[$];
    logic        got_l[$];
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_w.push_back(out_data);
            got_l.push_back(out_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input bit gap);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 128'(n < 100), 128'(1));
        tick();
        if (gap) begin
            in_valid = 1'b0;
            in_data  = 32'hbad0bad0;
            tick();
        end
    endtask

    task automatic send_block(input logic [127:0] k, input logic [127:0] c, input bit gap);
        for (int i = 0; i < 4; i++) send_word(32'(k >> (96 - 32 * i)), gap);
        for (int i = 0; i < 4; i++) send_word(32'(c >> (96 - 32 * i)), gap);
    endtask

    task automatic wait_words(input int n);
        int t;
        t = 0;
        while (got_w.size() < n && t < 200) begin
            tick();
            t++;
        end
        chk("out_words_wait", 128'(got_w.size() >= n), 128'(1));
    endtask

    task automatic check_block(input string name, input logic [127:0] p, input int base);
        if (got_w.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk({name, "_word"}, 128'(got_w[base + i]), 128'(32'(p >> (96 - 32 * i))));
                chk({name, "_last"}, 128'(got_l[base + i]), 128'(i == 3));
            end
        end
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_in_ready", 128'(in_ready), 128'(1));

        // FIPS-197 vector with latency measurement and backpressure on word 1
        out_ready = 1'b0;
        send_block(KA, CA, 1'b0);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 128'(n), 128'(S));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", 128'(out_data), 128'(32'h44556677));
        end
        out_ready = 1'b1;
        wait_words(4);
        chk("fips_count", 128'(got_w.size()), 128'(4));
        check_block("fips", PA, 0);
        got_w.delete();
        got_l.delete();
        repeat (2) tick();

        // Reset after 5 words discards the partial block
        for (int i = 0; i < 4; i++) send_word(32'(KB >> (96 - 32 * i)), 1'b0);
        send_word(32'(CB >> 96), 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("midreset_busy", 128'(busy), 128'(0));
        chk("midreset_in_ready", 128'(in_ready), 128'(1));
        chk("midreset_core_in", core_in, 128'(0));
        send_block(KB, CB, 1'b0);
        in_valid = 1'b0;
        wait_words(4);
        check_block("after_reset", PB, 0);
        got_w.delete();
        got_l.delete();
        repeat (2) tick();

        // Gapped input, then in_valid held high with junk through WAIT/SEND
        send_block(KA, CA, 1'b1);
        send_word(32'(KA >> 96), 1'b0);
        send_word(32'(KA >> 64), 1'b0);
        send_word(32'(KA >> 32), 1'b0);
        send_word(32'(KA), 1'b0);
        send_word(32'(CA >> 96), 1'b0);
        send_word(32'(CA >> 64), 1'b0);
        send_word(32'(CA >> 32), 1'b0);
        in_valid = 1'b1;
        in_data  = 32'(CA);
        tick();
        in_data  = 32'hdeadbeef;
        n = 0;
        while (!(out_valid && out_last) && n < 100) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        wait_words(8);
        check_block("gapped", PA, 0);
        check_block("held_valid", PA, 4);
        tick();
        chk("no_extra_accept_in", core_in, CA);
        got_w.delete();
        got_l.delete();
        repeat (2) tick();

        // Back-to-back blocks
        send_block(KA, CA, 1'b0);
        send_block(KB, CB, 1'b0);
        in_valid = 1'b0;
        wait_words(8);
        chk("b2b_count", 128'(got_w.size()), 128'(8));
        check_block("b2b_first", PA, 0);
        check_block("b2b_second", PB, 4);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_dec_word_io.md
AES_DEC_WORD_IO -- requirements
Module: aes_dec_word_io

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: clock edges allowed for the attached combinational 128-bit decryption core to settle; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream word valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-006 SHALL have port in_data, input, 32 bits: key or ciphertext word.
REQ-007 SHALL have port core_key, output, 128 bits: assembled cipher key driven to the decryption core.
REQ-008 SHALL have port core_in, output, 128 bits: assembled ciphertext driven to the decryption core.
REQ-009 SHALL have port core_out, input, 128 bits: plaintext returned by the decryption core.
REQ-010 SHALL have port out_valid, output, 1 bit: plaintext word valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts a word.
REQ-012 SHALL have port out_data, output, 32 bits: plaintext word.
REQ-013 SHALL have port out_last, output, 1 bit: marks the 4th plaintext word.
REQ-014 SHALL have port busy, output, 1 bit: high in WAIT and SEND.

Function
REQ-015 SHALL implement FSM states LOAD, WAIT, SEND; reset state LOAD.
REQ-016 SHALL drive in_ready = 1 only in LOAD; a word transfers on a rising edge with in_valid & in_ready.
REQ-017 SHALL count transfers with a 3-bit word index 0..7: words 0-3 go to core_key, words 4-7 to core_in, word 0/4 into bits [127:96], word 3/7 into bits [31:0].
REQ-018 SHALL update only the addressed 32-bit slice per transfer; other bits hold.
REQ-019 SHALL move LOAD->WAIT on the edge accepting word 7, clearing the settle counter to 0 and the word index to 0.
REQ-020 SHALL increment the settle counter each WAIT edge; on the edge where counter == SETTLE_CYCLES-1 it SHALL capture core_out into a 128-bit result register and move to SEND.
REQ-021 SHALL therefore assert out_valid exactly SETTLE_CYCLES cycles after the word-7 acceptance edge.
REQ-022 SHALL in SEND drive out_valid = 1, out_data = result slice selected by a 2-bit output index (0 -> [127:96] ... 3 -> [31:0]), out_last = 1 when index == 3.
REQ-023 SHALL advance the output index on out_valid & out_ready; on acceptance of index 3 SHALL return to LOAD with the index at 0 and out_valid low next cycle.
REQ-024 SHALL hold out_data, out_last stable while out_valid & !out_ready.
REQ-025 SHALL hold core_key and core_in unchanged throughout WAIT and SEND.
REQ-026 SHALL ignore in_valid/in_data outside LOAD; no word is lost since in_ready is 0.
REQ-027 SHALL drive out_valid = 0, out_last = 0, out_data = 0 outside SEND.
REQ-028 SHALL allow gaps in in_valid at any word; the index holds until the next transfer.

Reset
REQ-029 SHALL on rst_n low immediately set state LOAD, all indices/counters 0, core_key, core_in, result = 0; outputs: in_ready 1 after release, out_valid 0, out_data 0, out_last 0, busy 0.
REQ-030 SHALL on reset mid-LOAD, mid-WAIT or mid-SEND discard all partial data; the next block starts at word 0.

Verification
REQ-031 SHALL pass FIPS-197 vector: key words 00010203,04050607,08090a0b,0c0d0e0f; ciphertext words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a -> out words 00112233,44556677,8899aabb,ccddeeff, out_last on the 4th only, out_valid rising 2 cycles after the word-7 acceptance.
REQ-032 SHALL cover backpressure: out_ready low 5 cycles on word 1 -> out_data holds 44556677, no skip or duplication.
REQ-033 SHALL cover reset: rst_n pulsed low after 5 input words -> busy 0, in_ready 1, then a fresh 8-word load decrypts correctly.
REQ-034 SHALL cover input gaps: in_valid toggled every other cycle -> same plaintext; in_valid held high during WAIT/SEND -> no extra words accepted.
REQ-035 SHALL cover back-to-back blocks: two vectors streamed continuously -> two 4-word plaintext bursts in order, in_ready high the cycle after the first out_last transfer.
